wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Captures architectural write events (GRF and DM writes) emitted by the `mips` core each retiring cycle and buffers them in a FIFO. It then streams them to the simulation checker over a valid/ready handshake. It sits between the core's write-trace port and the bench-side comparator, so the core never stalls on checker back-pressure. Overflow is recorded rather than hidden.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DROP_ZERO`, 1: when 1, GRF events with `ev_addr == 0` are discarded silently. They are not counted as drops.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserted when 0.
- `flush` input 1: synchronous clear of FIFO contents. Status counters are kept.
- `ev_valid` input 1: event present this cycle.
- `ev_kind` input 1: 0 = GRF write, 1 = DM write.
- `ev_pc` input 32: PC of the writing instruction.
- `ev_addr` input 32: register number (zero-extended, 0–31) for GRF; word address for DM.
- `ev_data` input 32: written value.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: consumer accepts the head entry.
- `out_kind` output 1, `out_pc` output 32, `out_addr` output 32, `out_data` output 32: fields of the head entry.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set by the first dropped event.
- `drop_cnt` output 16: number of dropped events, saturating at 16'hFFFF.

## Operation
- Push condition: `ev_valid` and not filtered by `DROP_ZERO`.
- A push is accepted if `count < DEPTH`, or if a pop occurs in the same cycle.
- Pop condition: `out_valid && out_ready`.
- Full, push, and pop in the same cycle: both the push and the pop succeed and `count` is unchanged.
- Full, push, and no pop:
  - the event is dropped;
  - `overflow` is set to 1;
  - `drop_cnt` increments, saturating.
  - Existing entries are never overwritten.
- Empty with a pop request: no effect. `out_valid` is already 0.
- Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`. `count` is tracked separately, or derived from pointers that carry an extra wrap bit.
- `flush`:
  - next edge: pointers and `count` go to 0 and `out_valid` goes to 0;
  - any push or pop in the same cycle is ignored;
  - `overflow` and `drop_cnt` are kept.
- Reset (`reset == 0`), at any time including mid-stream, immediately forces:
  - `count` = 0, `out_valid` = 0, `overflow` = 0, `drop_cnt` = 0;
  - `out_kind`, `out_pc`, `out_addr`, `out_data` = 0.
  - Storage contents are don't-care.
- The output fields are driven from the head entry. They hold stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle. An event accepted at edge N is visible on `out_*` with `out_valid = 1` after edge N. There is no combinational bypass from `ev_*` to `out_*`.
- `count`, `overflow`, and `drop_cnt` update on the same edge as the push or pop that changes them.
- Sustained throughput is 1 event per cycle while `out_ready` is held at 1.
- `out_valid` depends only on registered state. `out_ready` does not combinationally affect `out_valid` or the data outputs within the same cycle.

## Structure
- The shared package `trace_pkg` holds:
  - `EV_GRF = 1'b0` and `EV_DM = 1'b1`;
  - `TRACE_W = 97`, the packed entry width as {kind, pc, addr, data};
  - the entry typedef.
- Sub-module `trace_fifo_mem`: a `DEPTH` × `TRACE_W` register array with one write port and one asynchronous read port. Pointer and flag logic stay in `wb_trace_buffer`.

## Test plan
- Reset, then one GRF event: pc=0x3000, addr=5, data=0x1234, kind=0, with `out_ready` held at 0.
  - After the edge: `out_valid` = 1, `count` = 1, and the fields match.
  - Raise `out_ready` for one cycle: `count` becomes 0 and `out_valid` becomes 0.
- With `DROP_ZERO` = 1, send a GRF event with addr=0, then a DM event with addr=0.
  - Only the DM entry is queued: `count` = 1, `drop_cnt` = 0.
- Keep `out_ready` at 0 and push 18 events with data = 0…17, `DEPTH` = 16.
  - `count` = 16, `overflow` = 1, `drop_cnt` = 2.
  - Draining returns data 0…15 in order.
- When full, push and pop in the same cycle for 20 cycles.
  - `count` stays at 16, `drop_cnt` does not change, and ordering is preserved across pointer wrap.
- With `count` = 7 and `overflow` = 1, assert `flush` together with `ev_valid`.
  - Next cycle: `count` = 0, `out_valid` = 0, and `overflow` is still 1.
- Pull `reset` to 0 mid-stream, between clock edges.
  - All outputs are 0 immediately, before the next edge.
  - After release, the first new event appears one cycle later.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the write-trace buffer.
// Entries are packed as {kind, pc, addr, data}.
package trace_pkg;

  localparam logic EV_GRF = 1'b0;
  localparam logic EV_DM = 1'b1;
  localparam int TRACE_W = 97;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: one write port, async read.
// Contents are not reset; validity lives in the pointer logic.
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  trace_t        wdata,
  input  logic [AW-1:0] raddr,
  output trace_t        rdata
);

  trace_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Buffers GRF/DM write events from the core for the checker.
// Overflow drops new events, never overwrites queued ones.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter bit DROP_ZERO = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          ev_valid,
  input  logic          ev_kind,
  input  logic [31:0]   ev_pc,
  input  logic [31:0]   ev_addr,
  input  logic [31:0]   ev_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_kind,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  trace_t        wentry;
  trace_t        head;
  logic          filtered;
  logic          push_req;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign wentry = '{kind: ev_kind, pc: ev_pc,
                    addr: ev_addr, data: ev_data};

  assign filtered = DROP_ZERO && (ev_kind == EV_GRF)
                    && (ev_addr == 32'd0);
  assign push_req = ev_valid && !filtered;
  assign full = (cnt == FULL_CNT);
  assign out_valid = (cnt != '0);
  assign pop = out_valid && out_ready && !flush;
  // A pop frees the slot the same-cycle push lands in.
  assign push = push_req && !flush && (!full || pop);
  assign drop = push_req && !flush && full && !pop;

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wentry),
    .raddr (rptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop) cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Gate so reset zeroes the fields without resetting storage.
  assign out_kind = out_valid & head.kind;
  assign out_pc   = out_valid ? head.pc : '0;
  assign out_addr = out_valid ? head.addr : '0;
  assign out_data = out_valid ? head.data : '0;
  assign count    = cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed + random bench for wb_trace_buffer.
// Reference is a plain queue with overflow/drop bookkeeping.
module tb_wb_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam bit DZ = 1'b1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_kind = 1'b0;
  logic [31:0]   ev_pc = '0;
  logic [31:0]   ev_addr = '0;
  logic [31:0]   ev_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_kind;
  logic [31:0]   out_pc;
  logic [31:0]   out_addr;
  logic [31:0]   out_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;

  wb_trace_buffer #(.DEPTH(DEPTH), .DROP_ZERO(DZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .ev_valid  (ev_valid),
    .ev_kind   (ev_kind),
    .ev_pc     (ev_pc),
    .ev_addr   (ev_addr),
    .ev_data   (ev_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_pc    (out_pc),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [96:0] q[$];
  logic m_ovf = 1'b0;
  int m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [96:0] h;
    chk({tag, ":valid"}, {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk({tag, ":count"}, 32'(count), 32'(q.size()));
    chk({tag, ":ovf"}, {31'b0, overflow}, {31'b0, m_ovf});
    chk({tag, ":drops"}, {16'b0, drop_cnt}, 32'(m_drop));
    if (q.size() != 0) begin
      h = q[0];
      chk({tag, ":kind"}, {31'b0, out_kind}, {31'b0, h[96]});
      chk({tag, ":pc"}, out_pc, h[95:64]);
      chk({tag, ":addr"}, out_addr, h[63:32]);
      chk({tag, ":data"}, out_data, h[31:0]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ":count"}, 32'(count), 32'd0);
    chk({tag, ":kind"}, {31'b0, out_kind}, 32'd0);
    chk({tag, ":pc"}, out_pc, 32'd0);
    chk({tag, ":addr"}, out_addr, 32'd0);
    chk({tag, ":data"}, out_data, 32'd0);
    chk({tag, ":ovf"}, {31'b0, overflow}, 32'd0);
    chk({tag, ":drops"}, {16'b0, drop_cnt}, 32'd0);
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cyc(input logic v, input logic k,
                     input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy,
                     input logic fl);
    bit want;
    bit popped;
    ev_valid = v;
    ev_kind = k;
    ev_pc = pc;
    ev_addr = a;
    ev_data = d;
    out_ready = rdy;
    flush = fl;
    want = v && !(DZ && k == EV_GRF && a == 32'd0);
    if (fl) begin
      q.delete();
    end else begin
      popped = rdy && q.size() != 0;
      if (popped) void'(q.pop_front());
      if (want) begin
        if (q.size() < DEPTH) begin
          q.push_back({k, pc, a, d});
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 65535) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    logic k;
    logic [31:0] a;
    // Reset held from time 0.
    #2;
    chk_zero("rst0");
    #5 reset = 1'b1;
    @(posedge clk);
    #1;
    compare_all("post_rst");

    // Single GRF event, then pop it.
    cyc(1'b1, EV_GRF, 32'h3000, 32'd5, 32'h1234, 1'b0, 1'b0);
    chk("one:count", 32'(count), 32'd1);
    chk("one:data", out_data, 32'h1234);
    idle(1'b0);
    chk("hold:pc", out_pc, 32'h3000);
    idle(1'b1);
    chk("pop:valid", {31'b0, out_valid}, 32'd0);

    // Zero-address filtering applies only to GRF events.
    cyc(1'b1, EV_GRF, 32'h3004, 32'd0, 32'hAAAA, 1'b0, 1'b0);
    cyc(1'b1, EV_DM, 32'h3008, 32'd0, 32'hBBBB, 1'b0, 1'b0);
    chk("dz:count", 32'(count), 32'd1);
    chk("dz:drops", {16'b0, drop_cnt}, 32'd0);
    chk("dz:kind", {31'b0, out_kind}, 32'd1);
    idle(1'b1);

    // Overflow: 18 pushes into 16 slots.
    for (int i = 0; i < 18; i++)
      cyc(1'b1, EV_DM, 32'h4000 + 32'(4 * i), 32'(i), 32'(i),
          1'b0, 1'b0);
    chk("ovf:count", 32'(count), 32'd16);
    chk("ovf:flag", {31'b0, overflow}, 32'd1);
    chk("ovf:drops", {16'b0, drop_cnt}, 32'd2);
    for (int i = 0; i < 16; i++) begin
      chk("drain:data", out_data, 32'(i));
      idle(1'b1);
    end

    // Refill, then push+pop at full across pointer wrap.
    for (int i = 0; i < 16; i++)
      cyc(1'b1, EV_GRF, 32'h5000, 32'd3, 32'd100 + 32'(i),
          1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("pp:head", out_data,
          (i < 16) ? 32'd100 + 32'(i) : 32'd200 + 32'(i - 16));
      cyc(1'b1, EV_GRF, 32'h6000, 32'd7, 32'd200 + 32'(i),
          1'b1, 1'b0);
      chk("pp:count", 32'(count), 32'd16);
    end
    chk("pp:drops", {16'b0, drop_cnt}, 32'd2);

    // Flush with a simultaneous event at count 7.
    for (int i = 0; i < 9; i++) idle(1'b1);
    chk("pre_fl:count", 32'(count), 32'd7);
    cyc(1'b1, EV_DM, 32'h7000, 32'd9, 32'h99, 1'b1, 1'b1);
    chk("fl:count", 32'(count), 32'd0);
    chk("fl:valid", {31'b0, out_valid}, 32'd0);
    chk("fl:ovf", {31'b0, overflow}, 32'd1);

    // Random traffic, first with heavy back-pressure.
    for (int i = 0; i < 400; i++) begin
      k = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cyc(1'($urandom_range(0, 3) != 0), k, $urandom, a, $urandom,
          (i < 200) ? 1'($urandom_range(0, 3) == 0)
                    : 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, EV_DM, 32'h8000, 32'(i + 1), 32'hC0 + 32'(i),
          1'b0, 1'b0);
    ev_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_zero("async_rst");
    q.delete();
    m_ovf = 1'b0;
    m_drop = 0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    compare_all("rst_rel");
    cyc(1'b1, EV_GRF, 32'h9000, 32'd4, 32'hFEED, 1'b0, 1'b0);
    chk("rst_ev:valid", {31'b0, out_valid}, 32'd1);
    chk("rst_ev:data", out_data, 32'hFEED);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
